// File: rtl/tank_pkg.sv
// Shared types and constants for the tank game datapath.
package tank_pkg;

  typedef enum logic [1:0] {UP, RIGHT, DOWN, LEFT} dir_t;

  typedef enum logic [1:0] {IDLE, FLIGHT, COOLDOWN} shell_state_t;

  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam logic [7:0]  KEY_SPACE = 8'h2C;

  // True when a signed offset lies within +/-half.
  function automatic logic within_half(input logic signed [11:0] d,
                                       input logic signed [11:0] half);
    return (d >= -half) && (d <= half);
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Registers a keycode and flags the first cycle a given key appears.
module key_edge_detect
  import tank_pkg::*;
#(
  parameter logic [7:0] KEY = KEY_SPACE
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       fire_edge
);

  logic [7:0] key_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) key_q <= '0;
    else       key_q <= keycode;
  end

  assign fire_edge = (keycode == KEY) && (key_q != KEY);

endmodule

// File: rtl/tank_shell.sv
// Per-player shell: fire on key press, move per frame, hit test, cooldown.
// Define TANK_SHELL_HITCOUNT_EN to build the saturating HitCount register.
module tank_shell
  import tank_pkg::*;
#(
  parameter logic [7:0]  FIRE_KEY        = KEY_SPACE,
  parameter int unsigned SHELL_STEP      = 4,
  parameter int unsigned TANK_HALF       = 8,
  parameter int unsigned COOLDOWN_FRAMES = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [1:0] Facing,
  input  logic [9:0] TargetX,
  input  logic [9:0] TargetY,
  output logic [9:0] ShellX,
  output logic [9:0] ShellY,
  output logic       ShellActive,
  output logic       Hit,
  output logic [3:0] HitCount
);

  localparam int unsigned CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic signed [10:0] STEP  = 11'(SHELL_STEP);
  localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - 1);
  localparam logic signed [10:0] Y_MAX = 11'(SCREEN_H - 1);
  localparam logic signed [11:0] HALF  = 12'(TANK_HALF);

  logic fire_edge;

  key_edge_detect #(.KEY(FIRE_KEY)) u_fire_key (
    .Clk       (Clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .fire_edge (fire_edge)
  );

  shell_state_t   state_q, state_d;
  dir_t           dir_q, dir_d;
  logic [9:0]     shell_x_q, shell_x_d, shell_y_q, shell_y_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           hit_q, hit_d;

  logic signed [10:0] cand_x, cand_y;
  logic signed [11:0] dx, dy;
  logic               oob, on_target;

  always_comb begin
    cand_x = $signed({1'b0, shell_x_q});
    cand_y = $signed({1'b0, shell_y_q});
    unique case (dir_q)
      UP:      cand_y = cand_y - STEP;
      RIGHT:   cand_x = cand_x + STEP;
      DOWN:    cand_y = cand_y + STEP;
      default: cand_x = cand_x - STEP;
    endcase
    oob = (cand_x < 0) || (cand_x > X_MAX) || (cand_y < 0) || (cand_y > Y_MAX);
    dx  = {cand_x[10], cand_x} - $signed({2'b00, TargetX});
    dy  = {cand_y[10], cand_y} - $signed({2'b00, TargetY});
    on_target = within_half(dx, HALF) && within_half(dy, HALF);
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    shell_x_d = shell_x_q;
    shell_y_d = shell_y_q;
    cnt_d     = cnt_q;
    hit_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire_edge) begin
          state_d   = FLIGHT;
          shell_x_d = TankX;
          shell_y_d = TankY;
          dir_d     = dir_t'(Facing);
        end
      end
      FLIGHT: begin
        // Bounds take priority: an off-screen candidate never moves or hits.
        if (frame_tick) begin
          if (oob) begin
            state_d = COOLDOWN;
            cnt_d   = CW'(COOLDOWN_FRAMES);
          end else begin
            shell_x_d = cand_x[9:0];
            shell_y_d = cand_y[9:0];
            if (on_target) begin
              hit_d   = 1'b1;
              state_d = COOLDOWN;
              cnt_d   = CW'(COOLDOWN_FRAMES);
            end
          end
        end
      end
      COOLDOWN: begin
        if (frame_tick) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      dir_q     <= UP;
      shell_x_q <= '0;
      shell_y_q <= '0;
      cnt_q     <= '0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      shell_x_q <= shell_x_d;
      shell_y_q <= shell_y_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
    end
  end

  assign ShellX      = shell_x_q;
  assign ShellY      = shell_y_q;
  assign ShellActive = (state_q == FLIGHT);
  assign Hit         = hit_q;

`ifdef TANK_SHELL_HITCOUNT_EN
  logic [3:0] hit_count_q, hit_count_d;

  always_comb begin
    hit_count_d = hit_count_q;
    if (hit_d && (hit_count_q != 4'hF)) hit_count_d = hit_count_q + 4'd1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) hit_count_q <= '0;
    else       hit_count_q <= hit_count_d;
  end

  assign HitCount = hit_count_q;
`else
  assign HitCount = 4'd0;
`endif

endmodule

// File: tb/tb_tank_shell.sv
// Directed bench for tank_shell with default parameters.
module tb_tank_shell;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic [7:0] keycode;
  logic [9:0] TankX, TankY, TargetX, TargetY;
  logic [1:0] Facing;
  logic [9:0] ShellX, ShellY;
  logic       ShellActive, Hit;
  logic [3:0] HitCount;

  int n_checks = 0;
  int n_fail   = 0;
  int hits     = 0;

  tank_shell dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .keycode     (keycode),
    .TankX       (TankX),
    .TankY       (TankY),
    .Facing      (Facing),
    .TargetX     (TargetX),
    .TargetY     (TargetY),
    .ShellX      (ShellX),
    .ShellY      (ShellY),
    .ShellActive (ShellActive),
    .Hit         (Hit),
    .HitCount    (HitCount)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_hc(input int n);
`ifdef TANK_SHELL_HITCOUNT_EN
    return (n > 15) ? 15 : n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press();
    keycode = 8'h00;
    cyc();
    keycode = 8'h2C;
    cyc();
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; keycode = 8'h00;
    TankX = 10'd100; TankY = 10'd200; Facing = 2'd1;
    TargetX = 10'd600; TargetY = 10'd50;
    repeat (3) cyc();
    check_val("rst_x", ShellX, 0);
    check_val("rst_y", ShellY, 0);
    check_val("rst_active", ShellActive, 0);
    check_val("rst_hit", Hit, 0);
    check_val("rst_hitcount", HitCount, 0);
    Reset = 1'b0;
    cyc();

    // Fire right from (100,200), then three frames
    keycode = 8'h2C;
    cyc();
    check_val("fire_active", ShellActive, 1);
    check_val("fire_x", ShellX, 100);
    check_val("fire_y", ShellY, 200);
    Facing = 2'd2;
    ticks(3);
    check_val("move3_x", ShellX, 112);
    check_val("move3_y", ShellY, 200);
    check_val("move3_active", ShellActive, 1);
    press();
    check_val("refire_in_flight_x", ShellX, 112);
    ticks(7);
    check_val("pre_reset_x", ShellX, 140);

    // Asynchronous reset mid-flight
    Reset = 1'b1;
    keycode = 8'h00;
    #2;
    check_val("async_rst_x", ShellX, 0);
    check_val("async_rst_y", ShellY, 0);
    check_val("async_rst_active", ShellActive, 0);
    cyc();
    Reset = 1'b0;
    cyc();
    cyc();
    check_val("post_rst_active", ShellActive, 0);

    // Left edge exit
    TankX = 10'd6; Facing = 2'd3;
    press();
    check_val("left_fire_x", ShellX, 6);
    tick();
    check_val("left_t1_x", ShellX, 2);
    check_val("left_t1_active", ShellActive, 1);
    tick();
    check_val("left_oob_active", ShellActive, 0);
    check_val("left_oob_x", ShellX, 2);
    check_val("left_oob_hit", Hit, 0);

    // Key held through cooldown; a press one frame early is dropped
    ticks(29);
    press();
    check_val("cool_press_ignored", ShellActive, 0);
    tick();
    cyc();
    cyc();
    check_val("held_no_refire", ShellActive, 0);
    keycode = 8'h00;
    cyc();
    keycode = 8'h2C;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    check_val("fire_tick_active", ShellActive, 1);
    check_val("fire_tick_nomove_x", ShellX, 6);
    ticks(2);
    check_val("second_oob_active", ShellActive, 0);
    ticks(30);

    // Hit on target at (130,200)
    TankX = 10'd100; TankY = 10'd200; Facing = 2'd1;
    TargetX = 10'd130; TargetY = 10'd200;
    press();
    ticks(5);
    check_val("hit_t5_x", ShellX, 120);
    check_val("hit_t5_hit", Hit, 0);
    check_val("hit_t5_active", ShellActive, 1);
    tick();
    hits++;
    check_val("hit_t6_x", ShellX, 124);
    check_val("hit_t6_hit", Hit, 1);
    check_val("hit_t6_count", HitCount, exp_hc(hits));
    check_val("hit_t6_active", ShellActive, 0);
    cyc();
    check_val("hit_pulse_end", Hit, 0);
    check_val("hit_hold_x", ShellX, 124);

    // Fifteen more hits: count saturates
    for (int i = 0; i < 15; i++) begin
      ticks(30);
      press();
      ticks(6);
      hits++;
      check_val("sat_hit", Hit, 1);
      check_val("sat_count", HitCount, exp_hc(hits));
    end
    check_val("sat_final", HitCount, exp_hc(16));

    // Bottom edge exit
    ticks(30);
    TankX = 10'd300; TankY = 10'd476; Facing = 2'd2;
    TargetX = 10'd600; TargetY = 10'd50;
    press();
    check_val("down_fire_y", ShellY, 476);
    tick();
    check_val("down_oob_active", ShellActive, 0);
    check_val("down_oob_y", ShellY, 476);
    check_val("down_oob_hit", Hit, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
